core_fsm: RTL and testbench
===========================

Name: core_fsm

Overview:
- Multi-cycle sequencer of the nano core; sits directly upstream of the instruction-fetch stage.
- Owns the program counter and the one-hot `StateBus` state vector (IF → EX → optional MEM → IF).
- Generates the `inst_L` latch request consumed by the fetch stage, and drives the shared instruction/data memory address and write strobe.
- Memory read latency is one cycle: the address issued in cycle N returns on mem_rdata in cycle N+1.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- hold  in  1  external stall (debug halt / bus wait)
- is_ls  in  1  decoder: current instruction is a load or store
- is_store  in  1  decoder: current instruction is a store
- jump  in  1  decoder/ALU: control transfer taken; valid in EX only
- jump_addr  in  32  control-transfer target
- data_addr  in  32  load/store effective address
- state  out  `StateBus`  one-hot state, bits `IF`, `EX`, `MEM`
- inst_L  out  1  instruction must be taken from the fetch-stage latch
- pc  out  32  current program counter
- mem_addr  out  32  shared memory address
- mem_we  out  1  memory write strobe
- pc_misalign  out  1  pc[1] set (fetch misaligned)
- inst_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rstn.
- Reset values: state=IF only; pc=RESET_PC; inst_L register=0; inst_cnt=0. Combinational outputs then follow: mem_addr=RESET_PC, mem_we=0.
- Reset asserted mid-instruction aborts it; no write is issued after rstn falls.
- Registered flag ls_q. Output inst_L = ls_q | (state[`EX] & is_ls).
  - inst_L is therefore high in the EX cycle of a load/store, so the fetch stage captures the instruction.
- mem_addr is combinational: data_addr in MEM; pc in IF and EX.
- mem_we = state[`MEM] & is_store & ~hold.
- Transitions (evaluated when hold=0):
  - IF → EX. If ls_q=1, clear ls_q; this is the load-data return/writeback cycle of the previous load/store.
  - EX, is_ls=0 → IF.
    - pc ← jump ? {jump_addr[31:1],1'b0} : pc+4.
    - inst_cnt += 1.
  - EX, is_ls=1 → MEM.
    - Set ls_q; pc unchanged.
    - jump is ignored for load/store instructions.
  - MEM → IF.
    - pc ← pc+4; inst_cnt += 1; ls_q stays 1.
- hold=1 freezes state, pc, ls_q and inst_cnt; mem_we=0. The memory address stays stable, so the re-read data is identical.
  - Exception: in IF with ls_q=1, hold is ignored and the transition to EX occurs, so returned load data is not lost.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- inst_cnt wraps modulo 2^CNT_W.
- pc_misalign = pc[1], combinational. The block does not trap; the sequence continues.
- state is always exactly one-hot. Any illegal encoding returns to IF on the next clock.

Test Plan:
- Reset and ALU op:
  - Stimulus: release rstn with RESET_PC=0; is_ls=0, jump=0.
  - Required: state 001→010→001, pc 0→4, mem_addr 0 in IF and EX, inst_cnt=1.
- Jump:
  - Stimulus: in EX, jump=1, jump_addr=32'h0000_0101.
  - Required: next pc=32'h100, pc_misalign=0.
  - Stimulus: jump_addr=32'h102.
  - Required: pc=32'h102, pc_misalign=1.
- Load:
  - Stimulus: pc=8; in EX, is_ls=1, is_store=0, data_addr=32'h40.
  - Required: inst_L=1 in EX, MEM and the following IF; mem_addr=32'h40 in MEM; mem_we=0; pc=12 after MEM; inst_L=0 in the next EX.
- Store with hold:
  - Stimulus: is_store=1, data_addr=32'h80; hold=1 for 3 cycles in MEM.
  - Required: state stays MEM, mem_addr=32'h80, mem_we=0 while held; mem_we=1 for exactly one cycle after hold drops.
- Hold exception:
  - Stimulus: hold=1 during the post-load IF cycle.
  - Required: state still advances to EX, inst_L drops; hold is then honoured in EX.
- Wrap and async reset:
  - Stimulus: pc=32'hFFFF_FFFC, ALU op.
  - Required: pc=0.
  - Stimulus: assert rstn low in MEM.
  - Required: state=IF, pc=RESET_PC and inst_L=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_fsm.sv
// core_fsm: multi-cycle IF/EX/MEM sequencer of the nano core.
// Owns the pc, one-hot state bus, fetch latch request and memory port.
module core_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hold,
  input  logic             is_ls,
  input  logic             is_store,
  input  logic             jump,
  input  logic [31:0]      jump_addr,
  input  logic [31:0]      data_addr,
  output logic [2:0]       state,
  output logic             inst_L,
  output logic [31:0]      pc,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic             pc_misalign,
  output logic [CNT_W-1:0] inst_cnt
);

  localparam int S_IF_B  = 0;
  localparam int S_EX_B  = 1;
  localparam int S_MEM_B = 2;

  typedef enum logic [2:0] {
    S_IF  = 3'b001,
    S_EX  = 3'b010,
    S_MEM = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           cur, nxt;
  logic [31:0]      pc_q, pc_d;
  logic             ls_q, ls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // state, pc, load/store flag and retired count registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur   <= S_IF;
      pc_q  <= RESET_PC;
      ls_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      cur   <= nxt;
      pc_q  <= pc_d;
      ls_q  <= ls_d;
      cnt_q <= cnt_d;
    end
  end

  // next state; IF after a load/store must advance even under hold
  // so the returning load data is consumed exactly once
  always_comb begin
    nxt   = S_IF;
    pc_d  = pc_q;
    ls_d  = ls_q;
    cnt_d = cnt_q;
    case (cur)
      S_IF: begin
        if (ls_q) begin
          nxt  = S_EX;
          ls_d = 1'b0;
        end else if (hold) begin
          nxt = S_IF;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        if (hold) begin
          nxt = S_EX;
        end else if (is_ls) begin
          nxt  = S_MEM;
          ls_d = 1'b1;
        end else begin
          nxt   = S_IF;
          pc_d  = jump ? {jump_addr[31:1], 1'b0}
                       : pc_q + 32'd4;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_MEM: begin
        if (hold) begin
          nxt = S_MEM;
        end else begin
          nxt   = S_IF;
          pc_d  = pc_q + 32'd4;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: nxt = S_IF;
    endcase
  end

  assign state       = cur;
  assign pc          = pc_q;
  assign inst_cnt    = cnt_q;
  assign pc_misalign = pc_q[1];
  assign inst_L      = ls_q | (cur[S_EX_B] & is_ls);
  assign mem_addr    = cur[S_MEM_B] ? data_addr : pc_q;
  assign mem_we      = cur[S_MEM_B] & is_store & ~hold;

  logic unused_if;
  assign unused_if = cur[S_IF_B];

endmodule

// File: tb/tb_core_fsm.sv
// tb_core_fsm: directed vectors for the core_fsm sequencer.
// Expected values are hand-derived per step.
module tb_core_fsm;

  logic        clk;
  logic        rstn;
  logic        hold;
  logic        is_ls;
  logic        is_store;
  logic        jump;
  logic [31:0] jump_addr;
  logic [31:0] data_addr;
  logic [2:0]  state;
  logic        inst_L;
  logic [31:0] pc;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        pc_misalign;
  logic [31:0] inst_cnt;

  int n_chk;
  int n_err;

  core_fsm #(
    .RESET_PC(32'h0000_0000),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .hold(hold),
    .is_ls(is_ls),
    .is_store(is_store),
    .jump(jump),
    .jump_addr(jump_addr),
    .data_addr(data_addr),
    .state(state),
    .inst_L(inst_L),
    .pc(pc),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .pc_misalign(pc_misalign),
    .inst_cnt(inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rstn = 1'b0;
    hold = 1'b0;
    is_ls = 1'b0;
    is_store = 1'b0;
    jump = 1'b0;
    jump_addr = '0;
    data_addr = '0;
    #12;
    chk("rst_state", 32'(state), 32'h1);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instL", 32'(inst_L), 32'h0);
    chk("rst_cnt", inst_cnt, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // ALU op at pc 0
    tick();
    chk("alu_ex_state", 32'(state), 32'h2);
    chk("alu_ex_maddr", mem_addr, 32'h0);
    chk("alu_ex_pc", pc, 32'h0);
    tick();
    chk("alu_if_state", 32'(state), 32'h1);
    chk("alu_if_pc", pc, 32'h4);
    chk("alu_if_maddr", mem_addr, 32'h4);
    chk("alu_cnt", inst_cnt, 32'd1);

    // jump to odd target, bit0 cleared
    tick();
    jump = 1'b1;
    jump_addr = 32'h0000_0101;
    tick();
    chk("jmp1_pc", pc, 32'h100);
    chk("jmp1_mis", 32'(pc_misalign), 32'h0);
    tick();
    jump_addr = 32'h0000_0102;
    tick();
    chk("jmp2_pc", pc, 32'h102);
    chk("jmp2_mis", 32'(pc_misalign), 32'h1);
    tick();
    jump_addr = 32'h0000_0008;
    tick();
    jump = 1'b0;
    chk("jmp3_pc", pc, 32'h8);
    chk("jmp_cnt", inst_cnt, 32'd4);

    // load at pc 8
    tick();
    is_ls = 1'b1;
    data_addr = 32'h40;
    #1;
    chk("ld_ex_state", 32'(state), 32'h2);
    chk("ld_ex_instL", 32'(inst_L), 32'h1);
    tick();
    chk("ld_mem_state", 32'(state), 32'h4);
    chk("ld_mem_maddr", mem_addr, 32'h40);
    chk("ld_mem_we", 32'(mem_we), 32'h0);
    chk("ld_mem_instL", 32'(inst_L), 32'h1);
    chk("ld_mem_pc", pc, 32'h8);
    tick();
    is_ls = 1'b0;
    #1;
    chk("ld_if_state", 32'(state), 32'h1);
    chk("ld_if_pc", pc, 32'hC);
    chk("ld_if_instL", 32'(inst_L), 32'h1);
    chk("ld_cnt", inst_cnt, 32'd5);
    tick();
    chk("ld_nex_state", 32'(state), 32'h2);
    chk("ld_nex_instL", 32'(inst_L), 32'h0);

    // store with 3 held cycles in MEM
    is_ls = 1'b1;
    is_store = 1'b1;
    data_addr = 32'h80;
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_hold_state", 32'(state), 32'h4);
      chk("st_hold_maddr", mem_addr, 32'h80);
      chk("st_hold_we", 32'(mem_we), 32'h0);
      if (i < 2) tick();
    end
    hold = 1'b0;
    #1;
    chk("st_we_pulse", 32'(mem_we), 32'h1);
    tick();
    is_ls = 1'b0;
    is_store = 1'b0;
    #1;
    chk("st_if_state", 32'(state), 32'h1);
    chk("st_if_we", 32'(mem_we), 32'h0);
    chk("st_if_pc", pc, 32'h10);
    chk("st_cnt", inst_cnt, 32'd6);
    chk("st_if_instL", 32'(inst_L), 32'h1);

    // hold ignored in post-load IF, honoured in EX
    hold = 1'b1;
    tick();
    chk("hx_ex_state", 32'(state), 32'h2);
    chk("hx_ex_instL", 32'(inst_L), 32'h0);
    tick();
    chk("hx_held_state", 32'(state), 32'h2);
    chk("hx_held_pc", pc, 32'h10);
    hold = 1'b0;
    tick();
    chk("hx_if_pc", pc, 32'h14);
    chk("hx_cnt", inst_cnt, 32'd7);

    // hold honoured in a plain IF
    hold = 1'b1;
    tick();
    chk("hif_state", 32'(state), 32'h1);
    hold = 1'b0;

    // pc wrap
    tick();
    jump = 1'b1;
    jump_addr = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    chk("wr_pre_pc", pc, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wr_pc", pc, 32'h0);
    chk("wr_cnt", inst_cnt, 32'd9);

    // async reset while in MEM of a store
    tick();
    is_ls = 1'b1;
    is_store = 1'b1;
    data_addr = 32'h20;
    tick();
    chk("ar_mem_state", 32'(state), 32'h4);
    chk("ar_mem_we", 32'(mem_we), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'h1);
    chk("ar_pc", pc, 32'h0);
    chk("ar_instL", 32'(inst_L), 32'h0);
    chk("ar_we", 32'(mem_we), 32'h0);
    chk("ar_cnt", inst_cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
